// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port burst arbiter in front of the Gowin SDRC user port
//
// Purpose: shares one SDRC user port between port 0 (video line fetcher) and
// port 1 (SPI command processor). One burst runs at a time: the command is
// issued with a single-cycle wr_n/rd_n strobe, data beats are counted, and
// write acks / read data are routed only to the granted port.
//
// Optional feature: define SDRAM_ARB_STARVE_GUARD_EN to bound the number of
// consecutive port-0 grants (STARVE_LIMIT) while port 1 is waiting.
//
// Ports:
//   clock, reset_n            clock shared with the SDRC, async active-low reset
//   pN_cmd_*                  command request/handshake (valid, ready, write, addr, len)
//   pN_wr_data / pN_wr_ack    write word and its consume pulse
//   pN_rd_data / pN_rd_valid  read word and its valid pulse
//   sdrc_*                    SDRC user-port strobes, address, length, data, status
//   grant                     port owning the current or last burst
//   busy                      burst in flight (ISSUE, WRITE or READ)
module sdram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_cmd_valid,
  output logic        p0_cmd_ready,
  input  logic        p0_cmd_write,
  input  logic [20:0] p0_cmd_addr,
  input  logic [6:0]  p0_cmd_len,
  input  logic [31:0] p0_wr_data,
  output logic        p0_wr_ack,
  output logic [31:0] p0_rd_data,
  output logic        p0_rd_valid,
  input  logic        p1_cmd_valid,
  output logic        p1_cmd_ready,
  input  logic        p1_cmd_write,
  input  logic [20:0] p1_cmd_addr,
  input  logic [6:0]  p1_cmd_len,
  input  logic [31:0] p1_wr_data,
  output logic        p1_wr_ack,
  output logic [31:0] p1_rd_data,
  output logic        p1_rd_valid,
  input  logic        sdrc_init_done,
  input  logic        sdrc_busy_n,
  input  logic        sdrc_wrd_ack,
  input  logic        sdrc_rd_valid,
  input  logic [31:0] sdrc_data_read,
  output logic        sdrc_wr_n,
  output logic        sdrc_rd_n,
  output logic [20:0] sdrc_addr,
  output logic [6:0]  sdrc_data_len,
  output logic [31:0] sdrc_data_write,
  output logic [3:0]  sdrc_dqm,
  output logic        sdrc_selfrefresh,
  output logic        sdrc_power_down,
  output logic        grant,
  output logic        busy
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        write_q, write_d;
  logic [20:0] addr_q, addr_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [1:0]  ready_q, ready_d;

  logic        arb_go;   // an arbitration is decided this cycle
  logic        pick;     // winner of the arbitration (0 or 1)
  logic        wr_beat;
  logic        rd_beat;

  assign arb_go = (state_q == S_IDLE) && sdrc_init_done && sdrc_busy_n &&
                  (p0_cmd_valid || p1_cmd_valid);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 7) ? 3 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q >= SW'(STARVE_LIMIT));
  assign pick    = p1_cmd_valid && (!p0_cmd_valid || starved);

  // Counts port-0 wins that happened while port 1 was waiting; any IDLE cycle
  // without a port-1 request means nobody is being starved.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!p1_cmd_valid) begin
        starve_d = '0;
      end else if (arb_go) begin
        starve_d = pick ? '0 : starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign pick = !p0_cmd_valid && p1_cmd_valid;
`endif

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      grant_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      ready_q <= ready_d;
    end
  end

  assign wr_beat = (state_q == S_WRITE) && sdrc_wrd_ack;
  assign rd_beat = (state_q == S_READ) && sdrc_rd_valid;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (sdrc_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!sdrc_init_done) begin
          state_d = S_INIT;
        end else if (arb_go) begin
          grant_d = pick;
          write_d = pick ? p1_cmd_write : p0_cmd_write;
          addr_d  = pick ? p1_cmd_addr  : p0_cmd_addr;
          len_d   = pick ? p1_cmd_len   : p0_cmd_len;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = write_q ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        if (wr_beat) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == len_q) state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_beat) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == len_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Registered command outputs are decoded from the next state so the strobe
  // and cmd_ready are low/high for exactly the ISSUE cycle.
  always_comb begin
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    ready_d = 2'b00;
    if (state_d == S_ISSUE) begin
      wr_n_d  = !write_d;
      rd_n_d  = write_d;
      ready_d = grant_d ? 2'b10 : 2'b01;
    end
  end

  assign sdrc_wr_n        = wr_n_q;
  assign sdrc_rd_n        = rd_n_q;
  assign sdrc_addr        = addr_q;
  assign sdrc_data_len    = len_q;
  assign sdrc_dqm         = 4'b0000;
  assign sdrc_selfrefresh = 1'b0;
  assign sdrc_power_down  = 1'b0;
  assign sdrc_data_write  = grant_q ? p1_wr_data : p0_wr_data;

  assign p0_cmd_ready = ready_q[0];
  assign p1_cmd_ready = ready_q[1];

  assign p0_wr_ack   = wr_beat && !grant_q;
  assign p1_wr_ack   = wr_beat && grant_q;
  assign p0_rd_valid = rd_beat && !grant_q;
  assign p1_rd_valid = rd_beat && grant_q;
  assign p0_rd_data  = sdrc_data_read;
  assign p1_rd_data  = sdrc_data_read;

  assign grant = grant_q;
  assign busy  = (state_q == S_ISSUE) || (state_q == S_WRITE) || (state_q == S_READ);

endmodule
